// File: rtl/decode_pkg.sv
// Shared RV32I decode types: op classes, opcodes, immediate formats and the
// ID/EX control bundle used by decode_stage and its testbench.
package decode_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;

  typedef enum logic [3:0] {
    OP_LUI     = 4'd0,
    OP_AUIPC   = 4'd1,
    OP_JAL     = 4'd2,
    OP_JALR    = 4'd3,
    OP_BRANCH  = 4'd4,
    OP_LOAD    = 4'd5,
    OP_STORE   = 4'd6,
    OP_OPIMM   = 4'd7,
    OP_OP      = 4'd8,
    OP_ILLEGAL = 4'd9
  } op_class_t;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic       valid;
    op_class_t  op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       jump;
  } id_ctrl_t;

  typedef struct packed {
    id_ctrl_t          ctrl;
    logic [XLEN-1:0]   imm;
  } dec_t;

  localparam id_ctrl_t BUBBLE_CTRL = '{
    valid:    1'b0,
    op:       OP_OPIMM,
    funct3:   3'd0,
    funct7b5: 1'b0,
    rs1:      5'd0,
    rs2:      5'd0,
    rd:       5'd0,
    regwrite: 1'b0,
    memread:  1'b0,
    memwrite: 1'b0,
    branch:   1'b0,
    jump:     1'b0
  };

  // The opcode bits never contribute to an immediate, so only [31:7] is taken.
  function automatic logic [XLEN-1:0] gen_imm(input logic [31:7] instr, input imm_fmt_t fmt);
    logic [XLEN-1:0] imm;
    case (fmt)
      IMM_I:    imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:    imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:    imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:    imm = {instr[31:12], 12'd0};
      IMM_J:    imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_NONE: imm = '0;
      default:  imm = '0;
    endcase
    return imm;
  endfunction

  // Source indices a class does not read are left at 0 so hazard compares never hit them.
  function automatic dec_t decode_instr(input logic [31:0] instr);
    dec_t d;
    logic writes_rd;
    logic uses_rs1;
    logic uses_rs2;
    d               = '0;
    d.ctrl          = BUBBLE_CTRL;
    d.ctrl.valid    = 1'b1;
    d.ctrl.funct3   = instr[14:12];
    d.ctrl.funct7b5 = instr[30];
    writes_rd       = 1'b0;
    uses_rs1        = 1'b0;
    uses_rs2        = 1'b0;
    case (instr[6:0])
      OPC_LUI: begin
        d.ctrl.op = OP_LUI;
        writes_rd = 1'b1;
        d.imm     = gen_imm(instr[31:7], IMM_U);
      end
      OPC_AUIPC: begin
        d.ctrl.op = OP_AUIPC;
        writes_rd = 1'b1;
        d.imm     = gen_imm(instr[31:7], IMM_U);
      end
      OPC_JAL: begin
        d.ctrl.op   = OP_JAL;
        writes_rd   = 1'b1;
        d.ctrl.jump = 1'b1;
        d.imm       = gen_imm(instr[31:7], IMM_J);
      end
      OPC_JALR: begin
        d.ctrl.op   = OP_JALR;
        writes_rd   = 1'b1;
        uses_rs1    = 1'b1;
        d.ctrl.jump = 1'b1;
        d.imm       = gen_imm(instr[31:7], IMM_I);
      end
      OPC_BRANCH: begin
        d.ctrl.op     = OP_BRANCH;
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
        d.ctrl.branch = 1'b1;
        d.imm         = gen_imm(instr[31:7], IMM_B);
      end
      OPC_LOAD: begin
        d.ctrl.op      = OP_LOAD;
        writes_rd      = 1'b1;
        uses_rs1       = 1'b1;
        d.ctrl.memread = 1'b1;
        d.imm          = gen_imm(instr[31:7], IMM_I);
      end
      OPC_STORE: begin
        d.ctrl.op       = OP_STORE;
        uses_rs1        = 1'b1;
        uses_rs2        = 1'b1;
        d.ctrl.memwrite = 1'b1;
        d.imm           = gen_imm(instr[31:7], IMM_S);
      end
      OPC_OPIMM: begin
        d.ctrl.op = OP_OPIMM;
        writes_rd = 1'b1;
        uses_rs1  = 1'b1;
        d.imm     = gen_imm(instr[31:7], IMM_I);
      end
      OPC_OP: begin
        d.ctrl.op = OP_OP;
        writes_rd = 1'b1;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
      end
      default: begin
        d.ctrl.op = OP_ILLEGAL;
      end
    endcase
    if (uses_rs1)  d.ctrl.rs1 = instr[19:15];
    if (uses_rs2)  d.ctrl.rs2 = instr[24:20];
    if (writes_rd) d.ctrl.rd  = instr[11:7];
    d.ctrl.regwrite = writes_rd && (instr[11:7] != 5'd0);
    return d;
  endfunction

endpackage

// File: rtl/regfile.sv
// Architectural register file: 32x32, two read ports, one write port,
// x0 hard-wired to zero, same-cycle write-through bypass on both reads.
module regfile
  import decode_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [NUM_REGS-1:0][XLEN-1:0] regs_q;
  logic [NUM_REGS-1:0][XLEN-1:0] regs_d;

  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != 5'd0)) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Bypass lets writeback and decode of a dependent instruction share a cycle.
  always_comb begin
    if (raddr1 == 5'd0) begin
      rdata1 = '0;
    end else if (we && (waddr == raddr1)) begin
      rdata1 = wdata;
    end else begin
      rdata1 = regs_q[raddr1];
    end
    if (raddr2 == 5'd0) begin
      rdata2 = '0;
    end else if (we && (waddr == raddr2)) begin
      rdata2 = wdata;
    end else begin
      rdata2 = regs_q[raddr2];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode, register file read, load-use
// hazard detection and the ID/EX pipeline register feeding execute.
module decode_stage
  import decode_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic        branchjump_miss,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rd,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        lwstall,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output op_class_t   id_op,
  output logic [2:0]  id_funct3,
  output logic        id_funct7b5,
  output logic [4:0]  id_rs1,
  output logic [4:0]  id_rs2,
  output logic [4:0]  id_rd,
  output logic [31:0] id_rs1val,
  output logic [31:0] id_rs2val,
  output logic [31:0] id_imm,
  output logic        id_regwrite,
  output logic        id_memread,
  output logic        id_memwrite,
  output logic        id_branch,
  output logic        id_jump
);

  dec_t       dec;
  dec_t       nop_dec;
  id_ctrl_t   bubble_ctrl;
  id_ctrl_t   ctrl_d, ctrl_q;
  logic [31:0] pc_d, pc_q;
  logic [31:0] rs1val_d, rs1val_q;
  logic [31:0] rs2val_d, rs2val_q;
  logic [31:0] imm_d, imm_q;
  logic [31:0] rf_rdata1, rf_rdata2;

  // A bubble is the configured NOP decoded normally, then marked invalid.
  always_comb begin
    dec               = decode_instr(instr_in);
    nop_dec           = decode_instr(NOP_INSTR);
    bubble_ctrl       = nop_dec.ctrl;
    bubble_ctrl.valid = 1'b0;
  end

  assign lwstall = ex_memread && (ex_rd != 5'd0) &&
                   ((ex_rd == dec.ctrl.rs1) || (ex_rd == dec.ctrl.rs2));

  regfile u_regfile (
    .clk    (clk),
    .rstn   (rstn),
    .raddr1 (dec.ctrl.rs1),
    .raddr2 (dec.ctrl.rs2),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2),
    .we     (wb_we),
    .waddr  (wb_rd),
    .wdata  (wb_data)
  );

  // Flush and load-use both insert a bubble; data fields are allowed to go stale.
  always_comb begin
    ctrl_d   = ctrl_q;
    pc_d     = pc_q;
    rs1val_d = rs1val_q;
    rs2val_d = rs2val_q;
    imm_d    = imm_q;
    if (branchjump_miss || lwstall) begin
      ctrl_d = bubble_ctrl;
      imm_d  = nop_dec.imm;
    end else if (enable) begin
      ctrl_d   = dec.ctrl;
      pc_d     = pc_in;
      rs1val_d = rf_rdata1;
      rs2val_d = rf_rdata2;
      imm_d    = dec.imm;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctrl_q   <= BUBBLE_CTRL;
      pc_q     <= '0;
      rs1val_q <= '0;
      rs2val_q <= '0;
      imm_q    <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      pc_q     <= pc_d;
      rs1val_q <= rs1val_d;
      rs2val_q <= rs2val_d;
      imm_q    <= imm_d;
    end
  end

  assign id_valid    = ctrl_q.valid;
  assign id_pc       = pc_q;
  assign id_op       = ctrl_q.op;
  assign id_funct3   = ctrl_q.funct3;
  assign id_funct7b5 = ctrl_q.funct7b5;
  assign id_rs1      = ctrl_q.rs1;
  assign id_rs2      = ctrl_q.rs2;
  assign id_rd       = ctrl_q.rd;
  assign id_rs1val   = rs1val_q;
  assign id_rs2val   = rs2val_q;
  assign id_imm      = imm_q;
  assign id_regwrite = ctrl_q.regwrite;
  assign id_memread  = ctrl_q.memread;
  assign id_memwrite = ctrl_q.memwrite;
  assign id_branch   = ctrl_q.branch;
  assign id_jump     = ctrl_q.jump;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: each scenario pushes its expected ID/EX
// contents when it drives fetch, then pops and compares after the clock edge.
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic        branchjump_miss;
  logic [31:0] pc_in;
  logic [31:0] instr_in;
  logic        ex_memread;
  logic [4:0]  ex_rd;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        lwstall;
  logic        id_valid;
  logic [31:0] id_pc;
  op_class_t   id_op;
  logic [2:0]  id_funct3;
  logic        id_funct7b5;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1val, id_rs2val, id_imm;
  logic        id_regwrite, id_memread, id_memwrite, id_branch, id_jump;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        valid;
    op_class_t   op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        branch;
    logic        jump;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];

  decode_stage #(.NOP_INSTR(32'h0000_0013)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .enable          (enable),
    .branchjump_miss (branchjump_miss),
    .pc_in           (pc_in),
    .instr_in        (instr_in),
    .ex_memread      (ex_memread),
    .ex_rd           (ex_rd),
    .wb_we           (wb_we),
    .wb_rd           (wb_rd),
    .wb_data         (wb_data),
    .lwstall         (lwstall),
    .id_valid        (id_valid),
    .id_pc           (id_pc),
    .id_op           (id_op),
    .id_funct3       (id_funct3),
    .id_funct7b5     (id_funct7b5),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rd           (id_rd),
    .id_rs1val       (id_rs1val),
    .id_rs2val       (id_rs2val),
    .id_imm          (id_imm),
    .id_regwrite     (id_regwrite),
    .id_memread      (id_memread),
    .id_memwrite     (id_memwrite),
    .id_branch       (id_branch),
    .id_jump         (id_jump)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic v, input op_class_t op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                              input logic rw, input logic mr, input logic mw,
                              input logic br, input logic jp, input logic [31:0] pc);
    exp_t e;
    e.valid = v; e.op = op; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm;
    e.regwrite = rw; e.memread = mr; e.memwrite = mw; e.branch = br; e.jump = jp; e.pc = pc;
    return e;
  endfunction

  task automatic set_idle();
    enable = 1'b0; branchjump_miss = 1'b0; ex_memread = 1'b0; ex_rd = 5'd0;
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0; pc_in = 32'd0; instr_in = 32'h0000_0013;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b expected 0", id_valid); end
    checks++; if (id_op !== OP_OPIMM) begin failures++; $display("FAIL reset_op: got %0d expected %0d", id_op, OP_OPIMM); end
    checks++; if (id_pc !== 32'd0) begin failures++; $display("FAIL reset_pc: got %h expected 0", id_pc); end
    checks++; if ({id_regwrite, id_memread, id_memwrite, id_branch, id_jump} !== 5'b0) begin
      failures++; $display("FAIL reset_ctrl: got %b expected 00000", {id_regwrite, id_memread, id_memwrite, id_branch, id_jump}); end
    checks++; if (id_rd !== 5'd0) begin failures++; $display("FAIL reset_rd: got %0d expected 0", id_rd); end
  endtask

  task automatic test_addi();
    exp_t e;
    instr_in = 32'h00500093; pc_in = 32'h100; enable = 1'b1;
    exp_q.push_back(mk(1'b1, OP_OPIMM, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100));
    tick();
    e = exp_q.pop_front();
    checks++; if (id_valid !== e.valid) begin failures++; $display("FAIL addi_valid: got %0b expected %0b", id_valid, e.valid); end
    checks++; if (id_op !== e.op) begin failures++; $display("FAIL addi_op: got %0d expected %0d", id_op, e.op); end
    checks++; if (id_rd !== e.rd) begin failures++; $display("FAIL addi_rd: got %0d expected %0d", id_rd, e.rd); end
    checks++; if (id_imm !== e.imm) begin failures++; $display("FAIL addi_imm: got %h expected %h", id_imm, e.imm); end
    checks++; if (id_regwrite !== e.regwrite) begin failures++; $display("FAIL addi_regwrite: got %0b expected %0b", id_regwrite, e.regwrite); end
    checks++; if (id_pc !== e.pc) begin failures++; $display("FAIL addi_pc: got %h expected %h", id_pc, e.pc); end
    checks++; if (id_rs2 !== e.rs2) begin failures++; $display("FAIL addi_rs2_masked: got %0d expected %0d", id_rs2, e.rs2); end
    enable = 1'b0;
  endtask

  task automatic test_hold();
    exp_t e;
    instr_in = 32'h002101B3; pc_in = 32'h104; enable = 1'b0;
    exp_q.push_back(mk(1'b1, OP_OPIMM, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100));
    tick();
    e = exp_q.pop_front();
    checks++; if (id_rd !== e.rd) begin failures++; $display("FAIL hold_rd: got %0d expected %0d", id_rd, e.rd); end
    checks++; if (id_pc !== e.pc) begin failures++; $display("FAIL hold_pc: got %h expected %h", id_pc, e.pc); end
    checks++; if (id_op !== e.op) begin failures++; $display("FAIL hold_op: got %0d expected %0d", id_op, e.op); end
  endtask

  task automatic test_bypass();
    exp_t e;
    instr_in = 32'h002101B3; pc_in = 32'h108; enable = 1'b1;
    wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'hDEADBEEF;
    exp_q.push_back(mk(1'b1, OP_OP, 5'd3, 5'd2, 5'd2, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h108));
    tick();
    e = exp_q.pop_front();
    wb_we = 1'b0; enable = 1'b0;
    checks++; if (id_rs1val !== 32'hDEADBEEF) begin failures++; $display("FAIL bypass_rs1val: got %h expected deadbeef", id_rs1val); end
    checks++; if (id_rs2val !== 32'hDEADBEEF) begin failures++; $display("FAIL bypass_rs2val: got %h expected deadbeef", id_rs2val); end
    checks++; if (id_op !== e.op) begin failures++; $display("FAIL bypass_op: got %0d expected %0d", id_op, e.op); end
    checks++; if (id_rd !== e.rd) begin failures++; $display("FAIL bypass_rd: got %0d expected %0d", id_rd, e.rd); end
  endtask

  task automatic test_regfile_array();
    wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'h12345678; enable = 1'b0;
    tick();
    wb_we = 1'b0; instr_in = 32'h00238433; pc_in = 32'h10C; enable = 1'b1;
    tick();
    checks++; if (id_rs1val !== 32'h12345678) begin failures++; $display("FAIL array_rs1val: got %h expected 12345678", id_rs1val); end
    checks++; if (id_rs2val !== 32'hDEADBEEF) begin failures++; $display("FAIL array_rs2val: got %h expected deadbeef", id_rs2val); end
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF; instr_in = 32'h000004B3;
    tick();
    checks++; if (id_rs1val !== 32'd0) begin failures++; $display("FAIL x0_bypass: got %h expected 0", id_rs1val); end
    wb_we = 1'b0;
    tick();
    checks++; if (id_rs2val !== 32'd0) begin failures++; $display("FAIL x0_write: got %h expected 0", id_rs2val); end
    enable = 1'b0;
  endtask

  task automatic test_load_use();
    exp_t e;
    ex_memread = 1'b1; ex_rd = 5'd5; instr_in = 32'h00028333; pc_in = 32'h110; enable = 1'b1;
    #1;
    checks++; if (lwstall !== 1'b1) begin failures++; $display("FAIL lu_stall_rs1: got %0b expected 1", lwstall); end
    exp_q.push_back(mk(1'b0, OP_OPIMM, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
    tick();
    e = exp_q.pop_front();
    checks++; if (id_valid !== e.valid) begin failures++; $display("FAIL lu_bubble_valid: got %0b expected %0b", id_valid, e.valid); end
    checks++; if (id_regwrite !== e.regwrite) begin failures++; $display("FAIL lu_bubble_regwrite: got %0b expected %0b", id_regwrite, e.regwrite); end
    ex_memread = 1'b0;
    #1;
    checks++; if (lwstall !== 1'b0) begin failures++; $display("FAIL lu_release: got %0b expected 0", lwstall); end
    exp_q.push_back(mk(1'b1, OP_OP, 5'd6, 5'd5, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h110));
    tick();
    e = exp_q.pop_front();
    checks++; if (id_valid !== e.valid) begin failures++; $display("FAIL lu_load_valid: got %0b expected %0b", id_valid, e.valid); end
    checks++; if (id_rd !== e.rd) begin failures++; $display("FAIL lu_load_rd: got %0d expected %0d", id_rd, e.rd); end
    checks++; if (id_rs1 !== e.rs1) begin failures++; $display("FAIL lu_load_rs1: got %0d expected %0d", id_rs1, e.rs1); end
    ex_memread = 1'b1; ex_rd = 5'd2; instr_in = 32'h002081B3;
    #1;
    checks++; if (lwstall !== 1'b1) begin failures++; $display("FAIL lu_stall_rs2: got %0b expected 1", lwstall); end
    set_idle();
  endtask

  task automatic test_no_stall();
    exp_t e;
    ex_memread = 1'b1; ex_rd = 5'd0; instr_in = 32'h00028333; enable = 1'b1;
    #1;
    checks++; if (lwstall !== 1'b0) begin failures++; $display("FAIL ns_exrd0: got %0b expected 0", lwstall); end
    ex_rd = 5'd5; instr_in = 32'h000282B7; pc_in = 32'h120;
    #1;
    checks++; if (lwstall !== 1'b0) begin failures++; $display("FAIL ns_lui: got %0b expected 0", lwstall); end
    exp_q.push_back(mk(1'b1, OP_LUI, 5'd5, 5'd0, 5'd0, 32'h00028000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h120));
    tick();
    e = exp_q.pop_front();
    checks++; if (id_op !== e.op) begin failures++; $display("FAIL ns_lui_op: got %0d expected %0d", id_op, e.op); end
    checks++; if (id_rs1 !== e.rs1) begin failures++; $display("FAIL ns_lui_rs1: got %0d expected %0d", id_rs1, e.rs1); end
    checks++; if (id_imm !== e.imm) begin failures++; $display("FAIL ns_lui_imm: got %h expected %h", id_imm, e.imm); end
    ex_rd = 5'd8; instr_in = 32'h0020A423; pc_in = 32'h124;
    #1;
    checks++; if (lwstall !== 1'b0) begin failures++; $display("FAIL ns_store_rdfield: got %0b expected 0", lwstall); end
    tick();
    checks++; if (id_funct3 !== 3'd2) begin failures++; $display("FAIL ns_store_funct3: got %0d expected 2", id_funct3); end
    set_idle();
  endtask

  task automatic test_flush();
    exp_t e;
    branchjump_miss = 1'b1; enable = 1'b1; instr_in = 32'h00500093; pc_in = 32'h130;
    exp_q.push_back(mk(1'b0, OP_OPIMM, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
    tick();
    e = exp_q.pop_front();
    checks++; if (id_valid !== e.valid) begin failures++; $display("FAIL flush_valid: got %0b expected %0b", id_valid, e.valid); end
    checks++; if (id_op !== e.op) begin failures++; $display("FAIL flush_op: got %0d expected %0d", id_op, e.op); end
    checks++; if (id_rd !== e.rd) begin failures++; $display("FAIL flush_rd: got %0d expected %0d", id_rd, e.rd); end
    checks++; if ({id_regwrite, id_memread, id_memwrite, id_branch, id_jump} !== 5'b0) begin
      failures++; $display("FAIL flush_ctrl: got %b expected 00000", {id_regwrite, id_memread, id_memwrite, id_branch, id_jump}); end
    ex_memread = 1'b1; ex_rd = 5'd5; instr_in = 32'h00028333;
    #1;
    checks++; if (lwstall !== 1'b1) begin failures++; $display("FAIL flush_lwstall: got %0b expected 1", lwstall); end
    tick();
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL flush_and_stall_valid: got %0b expected 0", id_valid); end
    set_idle();
  endtask

  task automatic test_illegal_and_branch();
    exp_t e;
    instr_in = 32'hFFFF_FFFF; pc_in = 32'h140; enable = 1'b1;
    exp_q.push_back(mk(1'b1, OP_ILLEGAL, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h140));
    tick();
    e = exp_q.pop_front();
    checks++; if (id_op !== e.op) begin failures++; $display("FAIL illegal_op: got %0d expected %0d", id_op, e.op); end
    checks++; if (id_valid !== e.valid) begin failures++; $display("FAIL illegal_valid: got %0b expected %0b", id_valid, e.valid); end
    checks++; if ({id_regwrite, id_memread, id_memwrite, id_branch, id_jump} !== 5'b0) begin
      failures++; $display("FAIL illegal_ctrl: got %b expected 00000", {id_regwrite, id_memread, id_memwrite, id_branch, id_jump}); end
    instr_in = 32'hFE208EE3; pc_in = 32'h144;
    exp_q.push_back(mk(1'b1, OP_BRANCH, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h144));
    tick();
    e = exp_q.pop_front();
    checks++; if (id_imm !== e.imm) begin failures++; $display("FAIL beq_imm: got %h expected %h", id_imm, e.imm); end
    checks++; if (id_rd !== e.rd) begin failures++; $display("FAIL beq_rd: got %0d expected %0d", id_rd, e.rd); end
    checks++; if (id_branch !== e.branch) begin failures++; $display("FAIL beq_branch: got %0b expected %0b", id_branch, e.branch); end
    checks++; if (id_rs2val !== 32'hDEADBEEF) begin failures++; $display("FAIL beq_rs2val: got %h expected deadbeef", id_rs2val); end
    set_idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] instrs [7];
    exp_t        exps   [7];
    exp_t        e;
    instrs[0] = 32'h008000EF; exps[0] = mk(1'b1, OP_JAL,    5'd1, 5'd0, 5'd0, 32'd8,         1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200);
    instrs[1] = 32'h0040A283; exps[1] = mk(1'b1, OP_LOAD,   5'd5, 5'd1, 5'd0, 32'd4,         1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h204);
    instrs[2] = 32'hFFF00213; exps[2] = mk(1'b1, OP_OPIMM,  5'd4, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h208);
    instrs[3] = 32'h0080006F; exps[3] = mk(1'b1, OP_JAL,    5'd0, 5'd0, 5'd0, 32'd8,         1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h20C);
    instrs[4] = 32'h0020A423; exps[4] = mk(1'b1, OP_STORE,  5'd0, 5'd1, 5'd2, 32'd8,         1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h210);
    instrs[5] = 32'h010280E7; exps[5] = mk(1'b1, OP_JALR,   5'd1, 5'd5, 5'd0, 32'd16,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h214);
    instrs[6] = 32'hFFFFF397; exps[6] = mk(1'b1, OP_AUIPC,  5'd7, 5'd0, 5'd0, 32'hFFFF_F000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h218);
    enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      instr_in = instrs[i];
      pc_in    = 32'h200 + 32'(4 * i);
      exp_q.push_back(exps[i]);
      tick();
      e = exp_q.pop_front();
      checks++; if (id_op !== e.op) begin failures++; $display("FAIL b2b_op[%0d]: got %0d expected %0d", i, id_op, e.op); end
      checks++; if ({id_rd, id_rs1, id_rs2} !== {e.rd, e.rs1, e.rs2}) begin
        failures++; $display("FAIL b2b_idx[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", i, id_rd, id_rs1, id_rs2, e.rd, e.rs1, e.rs2); end
      checks++; if (id_imm !== e.imm) begin failures++; $display("FAIL b2b_imm[%0d]: got %h expected %h", i, id_imm, e.imm); end
      checks++; if ({id_regwrite, id_memread, id_memwrite, id_branch, id_jump} !== {e.regwrite, e.memread, e.memwrite, e.branch, e.jump}) begin
        failures++; $display("FAIL b2b_ctrl[%0d]: got %b expected %b", i, {id_regwrite, id_memread, id_memwrite, id_branch, id_jump},
                             {e.regwrite, e.memread, e.memwrite, e.branch, e.jump}); end
      checks++; if (id_pc !== e.pc) begin failures++; $display("FAIL b2b_pc[%0d]: got %h expected %h", i, id_pc, e.pc); end
    end
    set_idle();
  endtask

  task automatic test_reset_mid();
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid: got %0b expected 0", id_valid); end
    checks++; if (id_op !== OP_OPIMM) begin failures++; $display("FAIL rmid_op: got %0d expected %0d", id_op, OP_OPIMM); end
    checks++; if (id_imm !== 32'd0) begin failures++; $display("FAIL rmid_imm: got %h expected 0", id_imm); end
    @(negedge clk);
    rstn = 1'b1;
    tick();
    instr_in = 32'h002101B3; enable = 1'b1;
    tick();
    checks++; if (id_rs1val !== 32'd0) begin failures++; $display("FAIL rmid_regfile: got %h expected 0", id_rs1val); end
    set_idle();
  endtask

  initial begin
    rstn = 1'b1;
    set_idle();
    #1 rstn = 1'b0;
    #2;
    test_reset();
    @(negedge clk);
    rstn = 1'b1;
    tick();
    test_addi();
    test_hold();
    test_bypass();
    test_regfile_array();
    test_load_use();
    test_no_stall();
    test_flush();
    test_illegal_and_branch();
    test_back_to_back();
    test_reset_mid();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_drain: got %0d expected 0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Second pipeline stage of the core: takes the fetched PC/instruction pair, decodes RV32I, reads the register file, and registers the result into the ID/EX pipeline register consumed by execute. Owns the architectural register file (written by writeback) and the load-use hazard detector; its `lwstall` output drives fetch's stall input. Control-transfer mispredicts from execute flush this stage to a bubble.

## Interface

- `NOP_INSTR`, default `32'h0000_0013`: encoding loaded as the held instruction on flush/reset (addi x0,x0,0).
- `clk`  in  1  clock.
- `rstn`  in  1  reset; one clock; reset is asynchronous and active-low.
- `enable`  in  1  advance the pipeline this cycle (no stall, no flush).
- `branchjump_miss`  in  1  execute detected a mispredict; the current decode contents are wrong-path.
- `pc_in`  in  32  PC of the instruction presented by fetch.
- `instr_in`  in  32  instruction presented by fetch (valid same cycle as `pc_in`).
- `ex_memread`  in  1  instruction currently in execute is a load.
- `ex_rd`  in  5  destination of the instruction in execute.
- `wb_we`  in  1  writeback register-write strobe.
- `wb_rd`  in  5  writeback destination.
- `wb_data`  in  32  writeback value.
- `lwstall`  out  1  combinational load-use hazard flag.
- `id_valid`  out  1  ID/EX slot holds a real instruction.
- `id_pc`  out  32  registered PC.
- `id_op`  out  4  `op_class_t` (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, ILLEGAL).
- `id_funct3`  out  3  / `id_funct7b5`  out  1  ALU/branch/mem sub-op.
- `id_rs1`, `id_rs2`, `id_rd`  out  5 each  register indices (0 when unused).
- `id_rs1val`, `id_rs2val`  out  32 each  operand values.
- `id_imm`  out  32  sign-extended immediate.
- `id_regwrite`, `id_memread`, `id_memwrite`, `id_branch`, `id_jump`  out  1 each  control bits.

## Operation

- Decode is combinational from `instr_in`; immediate formats I, S, B, U, J per RV32I; B/J immediates have bit 0 = 0.
- Unused source fields forced to 0 (e.g. rs2 for OPIMM/LOAD/JALR, both for LUI/AUIPC/JAL) so hazard logic never matches them.
- `id_rd` forced to 0 for BRANCH/STORE; `id_regwrite` = 1 only when rd ≠ 0 and class writes a register.
- Unknown opcode → `id_op`=ILLEGAL, all control bits 0, `id_valid`=1 (execute traps).
- Register file: 32×32, 2 read / 1 write, x0 reads 0, writes to x0 ignored. Write-through bypass: if `wb_we` and `wb_rd`==rsN≠0, rsN value = `wb_data` in the same cycle.
- `lwstall` = `ex_memread` ∧ `ex_rd`≠0 ∧ (`ex_rd`==rs1 ∨ `ex_rd`==rs2), using masked indices.
- ID/EX update priority each edge: `branchjump_miss` → bubble; else `lwstall` → bubble; else `enable` → load decoded values; else hold.
- Bubble: `id_valid`=0, all control bits 0, `id_op`=OPIMM, indices 0; `id_pc`/data fields may hold stale values.

## Timing

- Reset (async assert, sync deassert by surrounding logic): every output register 0, `id_op`=OPIMM, register file all zeros; `lwstall` follows inputs combinationally.
- Latency: `instr_in` at edge N → `id_*` valid after edge N+1.
- Write at edge N visible on reads from cycle N (bypass) and thereafter (array).
- `lwstall` high for exactly one cycle per load-use pair; the following cycle the load has left execute and the dependent instruction (held by fetch) loads normally.
- Simultaneous `branchjump_miss` and `lwstall`: flush wins, `lwstall` still asserted (fetch ignores it under miss).
- Reset mid-operation clears pipeline register immediately, no partial write to the register file.

## Structure

- `decode_pkg`: `op_class_t` enum, RV32I opcode constants, immediate-format enum, bubble default constant.
- Sub-module `regfile` (2R1W, async reset, bypass inside); decode/hazard/pipeline register in `decode_stage`.

## Test plan

- Reset, then `enable`=1, `instr_in`=`32'h00500093` (addi x1,x0,5) → next edge `id_op`=OPIMM, `id_rd`=1, `id_imm`=5, `id_regwrite`=1, `id_valid`=1.
- `wb_we`=1,`wb_rd`=2,`wb_data`=`32'hDEADBEEF` same cycle as `add x3,x2,x2` → `id_rs1val`=`id_rs2val`=`32'hDEADBEEF`.
- `ex_memread`=1,`ex_rd`=5, `instr_in`=`add x6,x5,x0` → `lwstall`=1, next `id_valid`=0; `ex_memread`=0 next cycle → instruction loads.
- Same with `ex_rd`=0 or instr `lui x5,1` → `lwstall`=0.
- `branchjump_miss`=1 with `enable`=1 → `id_valid`=0, all control 0.
- `instr_in`=`32'hFFFFFFFF` → `id_op`=ILLEGAL, `id_valid`=1, `id_regwrite`=0; `beq` with offset −4 → `id_imm`=`32'hFFFFFFFC`.
